// File: rtl/risk_sequencer.sv
// Command sequencer for the risk matrix engine: host commands are queued in a
// small FIFO and replayed onto the engine ports, each held for its latency.
module risk_sequencer #(
  parameter int unsigned LOGCNT  = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ALU_LAT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_func,
  input  logic [4:0]              cmd_reg,
  input  logic [10+LOGCNT-1:0]    cmd_addr,
  input  logic [10+LOGCNT-2:0]    cmd_stride_x,
  input  logic [10+LOGCNT-2:0]    cmd_stride_y,
  output logic [2:0]              risk_func,
  output logic [4:0]              risk_reg,
  output logic [10+LOGCNT-1:0]    risk_addr,
  output logic [10+LOGCNT-2:0]    risk_stride_x,
  output logic [10+LOGCNT-2:0]    risk_stride_y,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic [15:0]             retired
);

  localparam int unsigned AW      = 10 + LOGCNT;
  localparam int unsigned SW      = 10 + LOGCNT - 1;
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned LW      = PW + 1;
  localparam int unsigned EW      = 3 + 5 + AW + 2 * SW;
  localparam int unsigned MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int unsigned CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [15:0]   retired_q, retired_d;
  logic [2:0]    func_q, func_d;
  logic [4:0]    reg_q, reg_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] sx_q, sx_d;
  logic [SW-1:0] sy_q, sy_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic          push;
  logic          pop;
  logic [2:0]    h_func;
  logic [4:0]    h_reg;
  logic [AW-1:0] h_addr;
  logic [SW-1:0] h_sx;
  logic [SW-1:0] h_sy;

  assign {h_func, h_reg, h_addr, h_sx, h_sy} = mem_q[rd_ptr_q];

  // FIFO bookkeeping plus the IDLE/HOLD issue machine
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    retired_d = retired_q;
    func_d    = func_q;
    reg_d     = reg_q;
    addr_d    = addr_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    mem_d     = mem_q;
    pop       = 1'b0;
    push      = cmd_valid && ready_q;

    if (push) begin
      mem_d[wr_ptr_q] = {cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (h_func != 3'b000) begin
            func_d  = h_func;
            reg_d   = h_reg;
            addr_d  = h_addr;
            sx_d    = h_sx;
            sy_d    = h_sy;
            cnt_d   = (h_func == 3'b001 || h_func == 3'b010) ? CW'(MEM_LAT - 1)
                                                             : CW'(ALU_LAT - 1);
            state_d = S_HOLD;
          end else begin
            retired_d = retired_q + 16'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          retired_d = retired_q + 16'd1;
          func_d    = 3'b000;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    level_d = level_q + LW'(push) - LW'(pop);
    ready_d = level_d < LW'(DEPTH);
    busy_d  = (state_d == S_HOLD) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      retired_q <= '0;
      func_q    <= '0;
      reg_q     <= '0;
      addr_q    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      retired_q <= retired_d;
      func_q    <= func_d;
      reg_q     <= reg_d;
      addr_q    <= addr_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cmd_ready     = ready_q;
  assign risk_func     = func_q;
  assign risk_reg      = reg_q;
  assign risk_addr     = addr_q;
  assign risk_stride_x = sx_q;
  assign risk_stride_y = sy_q;
  assign level         = level_q;
  assign busy          = busy_q;
  assign retired       = retired_q;

endmodule
